// File: rtl/ram_block_responder_pkg.sv
// Shared widths, block/word helpers and FSM states for ram_block_responder.
package ram_block_responder_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BLOCK_WORDS  = 8;
  localparam int unsigned BLOCK_W      = WORD_W * BLOCK_WORDS;
  localparam int unsigned WORD_SEL_W   = 3;
  localparam int unsigned ADDR_W       = 30;
  localparam int unsigned BLOCK_ADDR_W = ADDR_W - WORD_SEL_W;

  typedef logic [BLOCK_W-1:0]      block_t;
  typedef logic [BLOCK_ADDR_W-1:0] block_addr_t;
  typedef logic [WORD_SEL_W-1:0]   word_sel_t;
  typedef logic [WORD_W-1:0]       word_t;

  typedef enum logic [2:0] {
    RRESP_IDLE  = 3'd0,
    RRESP_WAIT  = 3'd1,
    RRESP_BEAT  = 3'd2,
    RRESP_DRAIN = 3'd3,
    RRESP_DONE  = 3'd4
  } rresp_state_t;

  localparam word_sel_t LAST_BEAT = word_sel_t'(BLOCK_WORDS - 1);

  // Bit offset of word k inside a block.
  function automatic logic [7:0] word_lsb(input word_sel_t k);
    return {k, 5'd0};
  endfunction

endpackage

// File: rtl/ram_block_responder_word_sram.sv
// word_sram: single RW port 32-bit SRAM, synchronous write, one-cycle registered read.
module word_sram #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/ram_block_responder.sv
// Block refill/writeback responder: serialises one 256-bit request into eight SRAM word beats.
// Optional statistics counters are enabled with the RAM_RESP_STATS_EN macro.
module ram_block_responder
  import ram_block_responder_pkg::*;
#(
  parameter int unsigned ACCESS_LAT     = 2,
  parameter int unsigned MEM_WORDS_LOG2 = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wb_data,
  output logic               ready_o,
  output logic [BLOCK_W-1:0] block_o,
  output logic [31:0]        stat_rd_cnt,
  output logic [31:0]        stat_wr_cnt
);

  localparam int unsigned WAIT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  rresp_state_t      r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  word_sel_t         r_beat;
  block_addr_t       r_base;
  logic              r_we;
  block_t            r_wb_data;

  logic [ADDR_W-1:0]         w_word_addr;
  logic [MEM_WORDS_LOG2-1:0] w_sram_addr;
  logic                      w_sram_en;
  logic                      w_sram_we;
  word_t                     w_sram_rdata;
  word_sel_t                 w_prev_beat;
  logic                      w_unused;

  // Beat index never carries into the block base; high bits are dropped to alias the SRAM.
  assign w_word_addr = {r_base, r_beat};
  assign w_sram_addr = w_word_addr[MEM_WORDS_LOG2-1:0];
  assign w_sram_en   = (r_state == RRESP_BEAT) && !rst;
  assign w_sram_we   = w_sram_en && r_we;
  assign w_prev_beat = r_beat - word_sel_t'(1);
  assign w_unused    = ^{addr[WORD_SEL_W-1:0], w_word_addr};

  word_sram #(
    .ADDR_W (MEM_WORDS_LOG2)
  ) u_word_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (r_wb_data[word_lsb(r_beat) +: WORD_W]),
    .o_rdata (w_sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RRESP_IDLE;
      r_wait_cnt <= '0;
      r_beat     <= '0;
      r_base     <= '0;
      r_we       <= 1'b0;
      r_wb_data  <= '0;
      ready_o    <= 1'b0;
      block_o    <= '0;
    end else begin
      ready_o <= 1'b0;
      case (r_state)
        RRESP_IDLE: begin
          if (enable) begin
            r_base     <= addr[ADDR_W-1:WORD_SEL_W];
            r_we       <= we;
            r_wb_data  <= wb_data;
            r_beat     <= '0;
            r_wait_cnt <= '0;
            r_state    <= (ACCESS_LAT == 0) ? RRESP_BEAT : RRESP_WAIT;
          end
        end
        RRESP_WAIT: begin
          if (r_wait_cnt == WAIT_W'(ACCESS_LAT - 1)) begin
            r_state <= RRESP_BEAT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        RRESP_BEAT: begin
          // Read data lags the issued address by one cycle, so beat k fills slot k-1.
          if (!r_we && (r_beat != '0)) begin
            block_o[word_lsb(w_prev_beat) +: WORD_W] <= w_sram_rdata;
          end
          if (r_beat == LAST_BEAT) begin
            r_state <= RRESP_DRAIN;
          end else begin
            r_beat <= r_beat + word_sel_t'(1);
          end
        end
        RRESP_DRAIN: begin
          if (!r_we) begin
            block_o[word_lsb(LAST_BEAT) +: WORD_W] <= w_sram_rdata;
          end
          ready_o <= 1'b1;
          r_state <= RRESP_DONE;
        end
        RRESP_DONE: begin
          r_state <= RRESP_IDLE;
        end
        default: begin
          r_state <= RRESP_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_RESP_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (r_state == RRESP_DONE) begin
      if (r_we) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end else begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
    end
  end

  assign stat_rd_cnt = r_rd_cnt;
  assign stat_wr_cnt = r_wr_cnt;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_block_responder.sv
// Self-checking bench for ram_block_responder: request-level model plus directed literal checks.
module tb_ram_block_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned LOG2  = 17;
  localparam int unsigned LAT_B = 0;

  logic         clk = 1'b0;
  logic         rst, en1, en2, we;
  logic [29:0]  addr;
  logic [255:0] wb_data;
  logic         rdy1, rdy2;
  logic [255:0] blk1, blk2;
  logic [31:0]  rd1, wr1, rd2, wr2;

  always #5 clk = ~clk;

  ram_block_responder #(.ACCESS_LAT(LAT), .MEM_WORDS_LOG2(LOG2)) u_dut (
    .clk(clk), .rst(rst), .enable(en1), .we(we), .addr(addr), .wb_data(wb_data),
    .ready_o(rdy1), .block_o(blk1), .stat_rd_cnt(rd1), .stat_wr_cnt(wr1)
  );

  ram_block_responder #(.ACCESS_LAT(LAT_B), .MEM_WORDS_LOG2(6)) u_alias (
    .clk(clk), .rst(rst), .enable(en2), .we(we), .addr(addr), .wb_data(wb_data),
    .ready_o(rdy2), .block_o(blk2), .stat_rd_cnt(rd2), .stat_wr_cnt(wr2)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] b);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = b + 32'(k);
    return r;
  endfunction

  function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef RAM_RESP_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  // Request-level model of u_dut: timing from acceptance edge, words commit one per beat.
  logic [31:0]  m_mem [int unsigned];
  bit           m_busy, m_we, m_rdy;
  int unsigned  m_acc, m_rd, m_wr;
  logic [26:0]  m_base;
  logic [255:0] m_data, m_blk;

  function automatic int unsigned widx(input logic [26:0] b, input int unsigned k);
    logic [29:0] a;
    a = {b, 3'(k)};
    return 32'(a) & ((32'd1 << LOG2) - 32'd1);
  endfunction

  initial begin
    cyc = 0; m_busy = 0; m_rdy = 0; m_blk = '0; m_rd = 0; m_wr = 0;
    m_we = 0; m_acc = 0; m_base = '0; m_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy = 0; m_rdy = 0; m_blk = '0; m_rd = 0; m_wr = 0;
      end else if (m_busy) begin
        if (m_we && cyc >= m_acc + LAT + 1 && cyc <= m_acc + LAT + 8) begin
          int unsigned j;
          j = cyc - m_acc - LAT - 1;
          m_mem[widx(m_base, j)] = m_data[32*j +: 32];
        end
        if (cyc == m_acc + LAT + 9) begin
          m_rdy = 1;
          if (!m_we) for (int k = 0; k < 8; k++) m_blk[32*k +: 32] = m_mem[widx(m_base, k)];
        end else if (cyc == m_acc + LAT + 10) begin
          m_rdy = 0; m_busy = 0;
          if (m_we) m_wr++; else m_rd++;
        end
      end else if (en1) begin
        m_busy = 1; m_acc = cyc; m_base = addr[29:3]; m_we = we; m_data = wb_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("ready", {255'd0, rdy1}, {255'd0, m_rdy});
      if (m_rdy) check("block", blk1, m_blk);
      check("stat_rd", {224'd0, rd1}, {224'd0, exp_stat(m_rd)});
      check("stat_wr", {224'd0, wr1}, {224'd0, exp_stat(m_wr)});
    end
  end

  task automatic req(input bit sel, input bit w, input logic [29:0] a, input logic [255:0] d,
                     input bit scramble, output int unsigned t_drive, output int unsigned t_rdy);
    @(negedge clk);
    we = w; addr = a; wb_data = d;
    if (sel) en2 = 1'b1; else en1 = 1'b1;
    t_drive = cyc;
    t_rdy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sel ? rdy2 : rdy1) == 1'b1) begin
        t_rdy = cyc;
        break;
      end
      if (scramble) begin
        addr = 30'($urandom); we = 1'($urandom_range(0, 1));
        wb_data = {8{$urandom}}; en1 = 1'($urandom_range(0, 1));
      end
    end
    if (t_rdy == 0) begin
      tests++; fails++;
      $display("FAIL ready_timeout: no ready_o within 60 cycles of request at cycle %0d", t_drive);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    en1 = 1'b0; en2 = 1'b0;
  endtask

  int unsigned td, tr, td2, tr2, npulse;
  logic [255:0] exp_b;

  initial begin
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; we = 1'b0; addr = '0; wb_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Known contents for later reset/abort checks
    req(0, 1, {27'd7, 3'd0}, pat(32'hE0), 0, td, tr); idle();
    req(0, 1, {27'd5, 3'd0}, pat(32'hC0), 0, td, tr); idle();

    // Reset held with a write request pending
    @(negedge clk);
    rst = 1'b1; en1 = 1'b1; en2 = 1'b1; we = 1'b1; addr = {27'd7, 3'd5}; wb_data = '1;
    repeat (3) @(negedge clk);
    check("rst_block", blk1, '0);
    check("rst_ready", {255'd0, rdy1}, 256'd0);
    check("rst_stat_rd", {224'd0, rd1}, 256'd0);
    rst = 1'b0; en1 = 1'b0; en2 = 1'b0;
    req(0, 0, {27'd7, 3'd2}, '0, 0, td, tr);
    check("rst_no_write", blk1, pat(32'hE0));
    idle();

    // Abort a write with reset sampled during beat 3
    @(negedge clk);
    en1 = 1'b1; we = 1'b1; addr = {27'd5, 3'd0}; wb_data = pat(32'hB0);
    repeat (6) @(negedge clk);
    rst = 1'b1; en1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    repeat (16) begin
      @(negedge clk);
      npulse += 32'(rdy1);
    end
    check("abort_no_ready", 256'(npulse), 256'd0);

    // Write base 2, read it back through a different in-block offset
    req(0, 1, 30'h10, pat(32'hA0), 0, td, tr);
    check("wr_latency", 256'(tr - td), 256'd12);
    idle();
    req(0, 0, 30'h17, '0, 0, td, tr);
    check("rd_latency", 256'(tr - td), 256'd12);
    check("rd_block", blk1, pat(32'hA0));
    idle();

    // Back-to-back write then read; inputs scrambled while the write is busy
    req(0, 1, {27'd3, 3'd1}, pat(32'h5500), 1, td, tr);
    req(0, 0, {27'd3, 3'd6}, '0, 0, td2, tr2);
    check("b2b_gap", 256'(tr2 - tr), 256'(LAT + 11));
    check("b2b_block", blk1, pat(32'h5500));
    idle();

    // Aborted write left words 0..2 new and 3..7 old
    req(0, 0, {27'd5, 3'd3}, '0, 0, td, tr);
    exp_b = pat(32'hC0);
    for (int k = 0; k < 3; k++) exp_b[32*k +: 32] = 32'hB0 + 32'(k);
    check("abort_partial", blk1, exp_b);
    idle();

    // Since the abort reset: reads 0x17, base 3, base 5; writes base 2, base 3
    check("stat_rd_total", {224'd0, rd1}, {224'd0, exp_stat(3)});
    check("stat_wr_total", {224'd0, wr1}, {224'd0, exp_stat(2)});

    // Aliasing instance: 64-word SRAM, no access latency
    req(1, 1, 30'h0, pat(32'hD0), 0, td, tr);
    check("alias_wr_latency", 256'(tr - td), 256'd10);
    idle();
    req(1, 0, 30'h40, '0, 0, td, tr);
    check("alias_rd_latency", 256'(tr - td), 256'd10);
    check("alias_block", blk2, pat(32'hD0));
    idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
